// File: rtl/jpeg_line_fifo_unpacker_if.sv
// Line FIFO read port plus the outgoing pixel stream of the unpacker.
// Valid/ready: a pixel transfers on a rising rd_clk when pix_valid && pix_ready; while
// pix_valid is high and pix_ready is low the producer holds every pix_* signal unchanged.
interface jpeg_line_fifo_unpacker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PIX_WIDTH  = 8
);
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_empty;
   logic [PIX_WIDTH-1:0]  pix_data;
   logic                  pix_valid;
   logic                  pix_ready;
   logic                  pix_sol;
   logic                  pix_eol;
   logic                  pix_eof;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_data, fifo_rd_empty,
      output pix_data, pix_valid, pix_sol, pix_eol, pix_eof,
      input  pix_ready
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_data, fifo_rd_empty,
      input  pix_data, pix_valid, pix_sol, pix_eol, pix_eof,
      output pix_ready
   );
endinterface

// File: rtl/jpeg_line_fifo_unpacker.sv
// Pops packed words from the line FIFO, unpacks them lane 0 first into a registered pixel
// stream and tags each pixel with sol/eol/eof from the geometry latched at frame start.
module jpeg_line_fifo_unpacker #(
   parameter int DATA_WIDTH = 32,
   parameter int PIX_WIDTH  = 8,
   parameter int X_WIDTH    = 12,
   parameter int Y_WIDTH    = 12
) (
   input  logic                      rd_clk,
   input  logic                      rd_rst,
   input  logic [X_WIDTH-1:0]        cfg_width,
   input  logic [Y_WIDTH-1:0]        cfg_height,
   jpeg_line_fifo_unpacker_if.master bus,
   output logic                      busy
);
   localparam int LANES  = DATA_WIDTH / PIX_WIDTH;
   localparam int LANE_W = $clog2(LANES);

   logic                  inflight;
   logic [DATA_WIDTH-1:0] buf_mem [2];
   logic                  buf_wr_ptr;
   logic                  buf_rd_ptr;
   logic [1:0]            buf_cnt;
   logic [DATA_WIDTH-1:0] cur_word;
   logic                  cur_loaded;
   logic [LANE_W-1:0]     lane;
   logic [X_WIDTH-1:0]    x;
   logic [X_WIDTH-1:0]    w;
   logic [Y_WIDTH-1:0]    y;
   logic [Y_WIDTH-1:0]    h;

   logic [2:0]            occupancy;
   logic                  pop;
   logic                  src_avail;
   logic [DATA_WIDTH-1:0] src_word;
   logic                  xfer;
   logic                  load_out;
   logic                  take_buf;
   logic                  bypass;
   logic                  buf_wr;
   logic                  last_lane;
   logic [PIX_WIDTH-1:0]  next_pix;
   logic                  frame_start;
   logic [X_WIDTH-1:0]    eff_w;
   logic [Y_WIDTH-1:0]    eff_h;
   logic                  next_sol;
   logic                  next_eol;
   logic                  next_eof;

   // Word source for the next pixel: the partly unpacked word first, then the buffer head,
   // and with both empty the word arriving from the FIFO this cycle, so a cold start
   // reaches the output register one cycle after the read data appears.
   always_comb begin
      occupancy   = {1'b0, buf_cnt} + {2'b00, inflight};
      pop         = !rd_rst && !bus.fifo_rd_empty && (occupancy < 3'd2);
      src_avail   = cur_loaded || (buf_cnt != 2'd0) || inflight;
      src_word    = cur_loaded ? cur_word :
                    (buf_cnt != 2'd0) ? buf_mem[buf_rd_ptr] : bus.fifo_rd_data;
      xfer        = bus.pix_valid && bus.pix_ready;
      load_out    = src_avail && (!bus.pix_valid || bus.pix_ready);
      take_buf    = load_out && !cur_loaded && (buf_cnt != 2'd0);
      bypass      = load_out && !cur_loaded && (buf_cnt == 2'd0);
      buf_wr      = inflight && !bypass;
      last_lane   = (lane == LANE_W'(LANES - 1));
      next_pix    = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane == LANE_W'(i)) next_pix = src_word[i*PIX_WIDTH +: PIX_WIDTH];
      end
      frame_start = (x == '0) && (y == '0);
      eff_w       = frame_start ? cfg_width : w;
      eff_h       = frame_start ? cfg_height : h;
      next_sol    = (x == '0);
      next_eol    = (x == eff_w - 1'b1);
      next_eof    = next_eol && (y == eff_h - 1'b1);
   end

   assign bus.fifo_rd_en = pop;

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         inflight   <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         buf_wr_ptr <= 1'b0;
         buf_rd_ptr <= 1'b0;
         buf_cnt    <= 2'd0;
      end else begin
         inflight <= pop;
         if (buf_wr) begin
            buf_mem[buf_wr_ptr] <= bus.fifo_rd_data;
            buf_wr_ptr          <= !buf_wr_ptr;
         end
         if (take_buf) buf_rd_ptr <= !buf_rd_ptr;
         case ({buf_wr, take_buf})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         cur_word   <= '0;
         cur_loaded <= 1'b0;
         lane       <= '0;
      end else if (load_out) begin
         if (last_lane) begin
            lane       <= '0;
            cur_loaded <= 1'b0;
         end else begin
            lane <= lane + 1'b1;
            if (!cur_loaded) begin
               cur_word   <= src_word;
               cur_loaded <= 1'b1;
            end
         end
      end
   end

   // x/y track the position of the next pixel to enter the output register.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         bus.pix_data  <= '0;
         bus.pix_valid <= 1'b0;
         bus.pix_sol   <= 1'b0;
         bus.pix_eol   <= 1'b0;
         bus.pix_eof   <= 1'b0;
         x             <= '0;
         y             <= '0;
         w             <= '0;
         h             <= '0;
         busy          <= 1'b0;
      end else begin
         if (load_out) begin
            bus.pix_data  <= next_pix;
            bus.pix_valid <= 1'b1;
            bus.pix_sol   <= next_sol;
            bus.pix_eol   <= next_eol;
            bus.pix_eof   <= next_eof;
            if (frame_start) begin
               w <= cfg_width;
               h <= cfg_height;
            end
            if (next_eol) begin
               x <= '0;
               y <= next_eof ? '0 : y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end else if (xfer) begin
            bus.pix_valid <= 1'b0;
         end
         if (xfer && bus.pix_eof) busy <= 1'b0;
         if (load_out && frame_start) busy <= 1'b1;
      end
   end
endmodule
